way_hit_select: RTL and testbench
=================================

Name:
way_hit_select

Overview:
- Hit-detection and way-selection slice of a 4-way set-associative cache.
- Receives all ways of one indexed set and a request tag. Compares the tag against every way, qualifies each match with the way's valid bit, and selects the hitting line's data and status through a one-hot mux.
- Outputs are registered, one cycle after the request. They feed the cache controller's read/write and miss-handling logic.

Parameters:
- WAYS, 4, associativity; one-hot select width.
- TAG_BITS, 18, tag field width.
- LINE_SIZE_BYTES, 4, data bytes per line; LINE_SIZE_BITS = 8*LINE_SIZE_BYTES.
- LINE_WIDTH, derived = 3 + TAG_BITS + LINE_SIZE_BITS (53 at defaults), packed line width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  request strobe; set and tag are sampled when high.
- i_tag  in  TAG_BITS  request tag.
- i_set  in  WAYS*LINE_WIDTH  packed set; way w occupies bits [w*LINE_WIDTH +: LINE_WIDTH].
- o_valid  out  1  result valid, one cycle after i_req.
- o_hit  out  1  any way hit.
- o_hit_vec  out  WAYS  per-way hit (tag equal AND valid).
- o_way_idx  out  clog2(WAYS)  index of the selected way.
- o_line_data  out  LINE_SIZE_BITS  data field of the selected way.
- o_dirty  out  1  dirty bit of the selected way.
- o_lru  out  1  LRU bit of the selected way.
- o_multi_hit  out  1  more than one way hit.

Behaviour:
- Line format, MSB to LSB:
  - valid at [LINE_WIDTH-1]
  - dirty at [LINE_WIDTH-2]
  - lru at [LINE_WIDTH-3]
  - tag at [LINE_WIDTH-4 -: TAG_BITS]
  - data at [LINE_SIZE_BITS-1:0]
- Per way: hit[w] = (tag_w == i_tag) & valid_w. The compare is a full-width equality.
- Select: a one-hot mux driven by hit[].
  - If several ways hit, the lowest index wins and o_multi_hit=1.
  - If no way hits: o_hit=0, o_way_idx=0, o_line_data=0, o_dirty=0, o_lru=0.
- Latency: one register stage. All outputs update on the rising clk edge where i_req=1, and o_valid=1 in the following cycle.
- Cycle with i_req=0: o_valid clears to 0 and all other outputs hold their last values.
- Back-to-back requests: one result per cycle, with no bubbles.
- Reset: all outputs are 0 immediately and asynchronously. Reset asserted mid-request discards that request; o_valid stays 0 until the first i_req after reset release.
- A tag match on an invalid line is not a hit.
- All-zero tag with a valid line is a legal hit.

Optional Feature:
- Macro WAY_MULTI_HIT_CHECK_EN.
- Defined: o_multi_hit is computed as above (popcount(hit) > 1, registered with the other outputs).
- Undefined: o_multi_hit is tied to 0, and the priority logic still selects the lowest hitting index.

Decomposition:
- Shared package sa_cache_pkg holds:
  - TAG_BITS, LINE_SIZE_BITS, LINE_WIDTH
  - field offset constants VALID_POS, DIRTY_POS, LRU_POS, TAG_MSB
  - a packed cache_line_t typedef (valid, dirty, lru, tag, data)
- One natural sub-module, way_tag_compare: tag equality ANDed with the valid bit, instantiated WAYS times via generate. The one-hot mux and output register stay in the top.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; o_valid stays 0 after release without i_req.
- Single hit: way1 = {valid=1, dirty=0, lru=0, tag=18'h00002, data=32'h00000005}, other ways have different tags; i_req with i_tag=18'h00002 -> next cycle o_valid=1, o_hit=1, o_hit_vec=4'b0010, o_way_idx=1, o_line_data=32'h5.
- Invalid line: way3 has tag 18'h3ABCD with valid=0; i_tag=18'h3ABCD -> o_hit=0, o_hit_vec=0, o_line_data=0.
- Status fields: way2 = {valid=1, dirty=1, lru=1, tag=18'h00010, data=32'hDEADBEEF} -> o_way_idx=2, o_dirty=1, o_lru=1, o_line_data=32'hDEADBEEF.
- Multi-hit: ways 1 and 3 valid with tag 18'h00007 (data 32'h11 and 32'h33) -> o_hit_vec=4'b1010, o_way_idx=1, o_line_data=32'h11, o_multi_hit=1 (0 when WAY_MULTI_HIT_CHECK_EN is undefined).
- Back-to-back: i_req held for 3 cycles with tags hitting ways 0, 3, then missing -> o_way_idx 0, then 3, then o_hit=0 on consecutive cycles; drop i_req -> o_valid=0 with other outputs held.

Source files
------------

// File: rtl/sa_cache_pkg.sv
// Shared line-format constants and the packed line type for the set-associative cache.
package sa_cache_pkg;

   localparam int TAG_BITS        = 18;
   localparam int LINE_SIZE_BYTES = 4;
   localparam int LINE_SIZE_BITS  = 8 * LINE_SIZE_BYTES;
   localparam int LINE_WIDTH      = 3 + TAG_BITS + LINE_SIZE_BITS;

   localparam int VALID_POS = LINE_WIDTH - 1;
   localparam int DIRTY_POS = LINE_WIDTH - 2;
   localparam int LRU_POS   = LINE_WIDTH - 3;
   localparam int TAG_MSB   = LINE_WIDTH - 4;

   typedef struct packed {
      logic                      valid;
      logic                      dirty;
      logic                      lru;
      logic [TAG_BITS-1:0]       tag;
      logic [LINE_SIZE_BITS-1:0] data;
   } cache_line_t;

endpackage

// File: rtl/way_tag_compare.sv
// Per-way hit detect: full-width tag equality qualified by the line's valid bit.
module way_tag_compare #(
   parameter int TAG_BITS = sa_cache_pkg::TAG_BITS
) (
   input  logic [TAG_BITS-1:0] i_tag,
   input  logic [TAG_BITS-1:0] i_line_tag,
   input  logic                i_line_valid,
   output logic                o_hit
);

   assign o_hit = i_line_valid & (i_line_tag == i_tag);

endmodule

// File: rtl/way_hit_select.sv
// Hit detection and one-hot way select for one cache set, registered one cycle after i_req.
// WAY_MULTI_HIT_CHECK_EN: when defined, o_multi_hit flags more than one hitting way; else tied 0.
module way_hit_select #(
   parameter int WAYS            = 4,
   parameter int TAG_BITS        = sa_cache_pkg::TAG_BITS,
   parameter int LINE_SIZE_BYTES = sa_cache_pkg::LINE_SIZE_BYTES,
   localparam int LINE_SIZE_BITS = 8 * LINE_SIZE_BYTES,
   localparam int LINE_WIDTH     = 3 + TAG_BITS + LINE_SIZE_BITS,
   localparam int IDX_W          = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_req,
   input  logic [TAG_BITS-1:0]        i_tag,
   input  logic [WAYS*LINE_WIDTH-1:0] i_set,
   output logic                       o_valid,
   output logic                       o_hit,
   output logic [WAYS-1:0]            o_hit_vec,
   output logic [IDX_W-1:0]           o_way_idx,
   output logic [LINE_SIZE_BITS-1:0]  o_line_data,
   output logic                       o_dirty,
   output logic                       o_lru,
   output logic                       o_multi_hit
);

   localparam int VALID_OFS = LINE_WIDTH - 1;
   localparam int DIRTY_OFS = LINE_WIDTH - 2;
   localparam int LRU_OFS   = LINE_WIDTH - 3;
   localparam int TAG_OFS   = LINE_WIDTH - 4;

   logic [WAYS-1:0]           w_hit;
   logic [WAYS-1:0]           w_sel;
   logic [IDX_W-1:0]          w_idx;
   logic [LINE_SIZE_BITS-1:0] w_data;
   logic                      w_dirty;
   logic                      w_lru;
   logic                      w_multi;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      way_tag_compare #(.TAG_BITS(TAG_BITS)) u_cmp (
         .i_tag        (i_tag),
         .i_line_tag   (i_set[w*LINE_WIDTH + TAG_OFS -: TAG_BITS]),
         .i_line_valid (i_set[w*LINE_WIDTH + VALID_OFS]),
         .o_hit        (w_hit[w])
      );
   end

   // Isolate the lowest set bit so the mux below stays strictly one-hot.
   assign w_sel = w_hit & (~w_hit + WAYS'(1));

   always_comb begin
      w_idx   = '0;
      w_data  = '0;
      w_dirty = 1'b0;
      w_lru   = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (w_sel[w]) begin
            w_idx   = w_idx   | IDX_W'(w);
            w_data  = w_data  | i_set[w*LINE_WIDTH +: LINE_SIZE_BITS];
            w_dirty = w_dirty | i_set[w*LINE_WIDTH + DIRTY_OFS];
            w_lru   = w_lru   | i_set[w*LINE_WIDTH + LRU_OFS];
         end
      end
   end

`ifdef WAY_MULTI_HIT_CHECK_EN
   assign w_multi = |(w_hit & (w_hit - WAYS'(1)));
`else
   assign w_multi = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid     <= 1'b0;
         o_hit       <= 1'b0;
         o_hit_vec   <= '0;
         o_way_idx   <= '0;
         o_line_data <= '0;
         o_dirty     <= 1'b0;
         o_lru       <= 1'b0;
         o_multi_hit <= 1'b0;
      end else begin
         o_valid <= i_req;
         if (i_req) begin
            o_hit       <= |w_hit;
            o_hit_vec   <= w_hit;
            o_way_idx   <= w_idx;
            o_line_data <= w_data;
            o_dirty     <= w_dirty;
            o_lru       <= w_lru;
            o_multi_hit <= w_multi;
         end
      end
   end

endmodule

// File: tb/tb_way_hit_select.sv
// Scoreboard bench for way_hit_select: expectations queued at drive time, popped one cycle later.
module tb_way_hit_select;
   import sa_cache_pkg::*;

   localparam int WAYS = 4;

   typedef struct packed {
      logic        valid;
      logic        hit;
      logic [3:0]  hit_vec;
      logic [1:0]  idx;
      logic [31:0] data;
      logic        dirty;
      logic        lru;
      logic        multi;
   } exp_t;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       i_req = 1'b0;
   logic [TAG_BITS-1:0]        i_tag = '0;
   logic [WAYS*LINE_WIDTH-1:0] i_set = '0;
   logic                       o_valid, o_hit, o_dirty, o_lru, o_multi_hit;
   logic [WAYS-1:0]            o_hit_vec;
   logic [1:0]                 o_way_idx;
   logic [LINE_SIZE_BITS-1:0]  o_line_data;

   int          n_total = 0;
   int          n_bad   = 0;
   exp_t        exp_q[$];
   exp_t        last_exp = '0;
   cache_line_t cl[WAYS];

   way_hit_select dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_tag(i_tag), .i_set(i_set),
      .o_valid(o_valid), .o_hit(o_hit), .o_hit_vec(o_hit_vec), .o_way_idx(o_way_idx),
      .o_line_data(o_line_data), .o_dirty(o_dirty), .o_lru(o_lru), .o_multi_hit(o_multi_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_total++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, want, $time);
      end
   endtask

   function automatic cache_line_t mk(input logic v, input logic d, input logic l,
                                      input logic [TAG_BITS-1:0] t, input logic [31:0] dat);
      cache_line_t c;
      c.valid = v; c.dirty = d; c.lru = l; c.tag = t; c.data = dat;
      return c;
   endfunction

   function automatic exp_t model(input logic [TAG_BITS-1:0] tag);
      exp_t e;
      int   cnt;
      e = '0;
      e.valid = 1'b1;
      cnt = 0;
      for (int w = 0; w < WAYS; w++) begin
         if (cl[w].valid && cl[w].tag == tag) begin
            e.hit_vec[w] = 1'b1;
            if (cnt == 0) begin
               e.idx   = 2'(w);
               e.data  = cl[w].data;
               e.dirty = cl[w].dirty;
               e.lru   = cl[w].lru;
            end
            cnt++;
         end
      end
      e.hit = (cnt > 0);
`ifdef WAY_MULTI_HIT_CHECK_EN
      e.multi = (cnt > 1);
`else
      e.multi = 1'b0;
`endif
      return e;
   endfunction

   task automatic check_out(input exp_t e);
      chk("valid",   64'(o_valid),     64'(e.valid));
      chk("hit",     64'(o_hit),       64'(e.hit));
      chk("hit_vec", 64'(o_hit_vec),   64'(e.hit_vec));
      chk("way_idx", 64'(o_way_idx),   64'(e.idx));
      chk("data",    64'(o_line_data), 64'(e.data));
      chk("dirty",   64'(o_dirty),     64'(e.dirty));
      chk("lru",     64'(o_lru),       64'(e.lru));
      chk("multi",   64'(o_multi_hit), 64'(e.multi));
   endtask

   // One cycle: check the previous cycle's result, then drive and queue this cycle's expectation.
   task automatic step(input logic req, input logic [TAG_BITS-1:0] tag);
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) check_out(exp_q.pop_front());
      i_req = req;
      i_tag = tag;
      i_set = {cl[3], cl[2], cl[1], cl[0]};
      if (req) e = model(tag);
      else begin
         e = last_exp;
         e.valid = 1'b0;
      end
      last_exp = e;
      exp_q.push_back(e);
   endtask

   task automatic clear_set();
      for (int w = 0; w < WAYS; w++) cl[w] = mk(1'b1, 1'b0, 1'b0, 18'(32'h100 + w), 32'(w));
   endtask

   initial begin
      clear_set();
      #7;
      check_out('0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, '0);
      step(1'b0, '0);

      // single hit on way 1
      cl[1] = mk(1'b1, 1'b0, 1'b0, 18'h00002, 32'h00000005);
      step(1'b1, 18'h00002);
      // tag match on invalid line
      cl[3] = mk(1'b0, 1'b1, 1'b1, 18'h3ABCD, 32'hCAFE0000);
      step(1'b1, 18'h3ABCD);
      // status fields from way 2
      cl[2] = mk(1'b1, 1'b1, 1'b1, 18'h00010, 32'hDEADBEEF);
      step(1'b1, 18'h00010);
      step(1'b0, '0);
      // multi-hit, lowest index wins
      clear_set();
      cl[1] = mk(1'b1, 1'b0, 1'b1, 18'h00007, 32'h11);
      cl[3] = mk(1'b1, 1'b1, 1'b0, 18'h00007, 32'h33);
      step(1'b1, 18'h00007);
      // all-zero tag on a valid line
      cl[0] = mk(1'b1, 1'b1, 1'b0, 18'h00000, 32'h0BADF00D);
      step(1'b1, 18'h00000);
      // back-to-back: way 0, way 3, miss, then idle holds
      clear_set();
      step(1'b1, 18'h00100);
      step(1'b1, 18'h00103);
      step(1'b1, 18'h2FFFF);
      step(1'b0, 18'h00101);
      step(1'b0, 18'h00102);

      // random back-to-back traffic over a small tag space
      for (int i = 0; i < 40; i++) begin
         for (int w = 0; w < WAYS; w++)
            cl[w] = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       18'($urandom_range(0, 3)), $urandom);
         step(1'($urandom_range(0, 3) != 0), 18'($urandom_range(0, 3)));
      end

      // reset asserted while a hitting request is pending
      clear_set();
      step(1'b1, 18'h00102);
      step(1'b1, 18'h00101);
      #2;
      rst = 1'b1;
      #1;
      check_out('0);
      exp_q.delete();
      last_exp = '0;
      @(negedge clk);
      rst = 1'b0;
      i_req = 1'b0;
      step(1'b0, 18'h00101);
      step(1'b0, 18'h00101);
      step(1'b1, 18'h00101);
      step(1'b0, '0);
      @(negedge clk);
      if (exp_q.size() > 0) check_out(exp_q.pop_front());

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
